// File: rtl/gpa_fhdo_seq.sv
// Update sequencer for gpa_fhdo_iface: DAC80504 init, then masked 4-channel updates.
// Optional: GPA_FHDO_SEQ_SKIP_UNCHANGED_EN suppresses channels equal to the last value sent.
module gpa_fhdo_seq #(
    parameter logic [23:0] INIT_WORD0    = 24'h020000,
    parameter logic [23:0] INIT_WORD1    = 24'h040000,
    parameter int unsigned HOLDOFF       = 2,
    parameter logic [7:0]  DAC_BASE_ADDR = 8'h08
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        upd_valid_i,
    output logic        upd_ready_o,
    input  logic [63:0] upd_data_i,
    input  logic [3:0]  upd_mask_i,
    output logic [31:0] iface_data_o,
    output logic        iface_valid_o,
    input  logic        iface_busy_i,
    output logic        init_done_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam logic [3:0] HOLD_LAST = 4'(HOLDOFF - 1);

    typedef enum logic [2:0] {
        S_INIT_ISSUE,
        S_INIT_HOLD,
        S_INIT_WAIT,
        S_IDLE,
        S_ISSUE,
        S_HOLD,
        S_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic        init_idx_q;
    logic        init_done_q, init_done_d;
    logic [3:0]  hold_cnt_q;
    logic [3:0]  rem_q;
    logic [3:0]  rem_after;
    logic [3:0]  eff_mask;
    logic [63:0] data_q;
    logic [1:0]  ptr;
    logic [15:0] ptr_val;
    logic        hold_end;
    logic        accept;
    logic [31:0] iface_data_q;
    logic        valid_q, ready_q, busy_q, done_q;

    assign iface_data_o  = iface_data_q;
    assign iface_valid_o = valid_q;
    assign upd_ready_o   = ready_q;
    assign init_done_o   = init_done_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

    function automatic logic [1:0] lowest_set(input logic [3:0] m);
        logic [1:0] res;
        logic       found;
        res   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (m[i] && !found) begin
                res   = 2'(i);
                found = 1'b1;
            end
        end
        return res;
    endfunction

`ifdef GPA_FHDO_SEQ_SKIP_UNCHANGED_EN
    logic [63:0] shadow_q;

    always_comb begin
        eff_mask = upd_mask_i;
        for (int unsigned i = 0; i < 4; i++) begin
            if (upd_data_i[16*i +: 16] == shadow_q[16*i +: 16])
                eff_mask[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            shadow_q <= '0;
        else if (state_q == S_ISSUE)
            shadow_q[{ptr, 4'b0000} +: 16] <= ptr_val;
    end
`else
    assign eff_mask = upd_mask_i;
`endif

    // Remaining-channel mask: the pointer is always its lowest set bit, and the
    // word being issued is the last one when clearing that bit empties the mask.
    always_comb begin
        ptr       = lowest_set(rem_q);
        ptr_val   = data_q[{ptr, 4'b0000} +: 16];
        rem_after = rem_q & ~(4'b0001 << ptr);
        hold_end  = (hold_cnt_q == HOLD_LAST);
        accept    = (state_q == S_IDLE) && init_done_q && upd_valid_i;
    end

    always_comb begin
        state_d     = state_q;
        init_done_d = init_done_q;
        case (state_q)
            S_INIT_ISSUE: state_d = S_INIT_HOLD;
            S_INIT_HOLD:  if (hold_end) state_d = S_INIT_WAIT;
            S_INIT_WAIT: begin
                if (!iface_busy_i) begin
                    if (init_idx_q) begin
                        state_d     = S_IDLE;
                        init_done_d = 1'b1;
                    end else begin
                        state_d = S_INIT_ISSUE;
                    end
                end
            end
            S_IDLE:  if (accept && (eff_mask != 4'd0)) state_d = S_ISSUE;
            S_ISSUE: state_d = S_HOLD;
            S_HOLD:  if (hold_end) state_d = S_WAIT;
            S_WAIT: begin
                if (!iface_busy_i)
                    state_d = (rem_q == 4'd0) ? S_IDLE : S_ISSUE;
            end
            default: state_d = S_INIT_ISSUE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_INIT_ISSUE;
            init_idx_q   <= 1'b0;
            init_done_q  <= 1'b0;
            hold_cnt_q   <= '0;
            rem_q        <= '0;
            data_q       <= '0;
            iface_data_q <= '0;
            valid_q      <= 1'b0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_done_q <= init_done_d;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            // Status outputs are registered from the next state so they stay 0 in reset.
            busy_q      <= (state_d != S_IDLE);
            ready_q     <= (state_d == S_IDLE) && init_done_d;

            if (state_q == S_HOLD || state_q == S_INIT_HOLD)
                hold_cnt_q <= hold_cnt_q + 4'd1;
            else
                hold_cnt_q <= '0;

            case (state_q)
                S_INIT_ISSUE: begin
                    valid_q      <= 1'b1;
                    iface_data_q <= {8'd0, (init_idx_q ? INIT_WORD1 : INIT_WORD0)};
                end
                S_INIT_WAIT: begin
                    if (!iface_busy_i)
                        init_idx_q <= 1'b1;
                end
                S_IDLE: begin
                    if (accept) begin
                        data_q <= upd_data_i;
                        rem_q  <= eff_mask;
                        if (eff_mask == 4'd0)
                            done_q <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    valid_q      <= 1'b1;
                    iface_data_q <= {5'd0, ptr, (rem_after == 4'd0),
                                     DAC_BASE_ADDR + {6'd0, ptr}, ptr_val};
                    rem_q        <= rem_after;
                end
                S_WAIT: begin
                    if (!iface_busy_i && (rem_q == 4'd0))
                        done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gpa_fhdo_seq.sv
// Randomized self-checking bench for gpa_fhdo_seq with a word-list reference model
// and a behavioural iface responder that holds busy for a random number of cycles.
module tb_gpa_fhdo_seq;

    localparam int unsigned HOLDOFF = 2;
    localparam logic [31:0] INIT0 = 32'h0002_0000;
    localparam logic [31:0] INIT1 = 32'h0004_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        upd_valid_i = 1'b0;
    logic        upd_ready_o;
    logic [63:0] upd_data_i = '0;
    logic [3:0]  upd_mask_i = '0;
    logic [31:0] iface_data_o;
    logic        iface_valid_o;
    logic        iface_busy_i = 1'b0;
    logic        init_done_o;
    logic        busy_o;
    logic        done_o;

    gpa_fhdo_seq #(
        .INIT_WORD0(24'h020000),
        .INIT_WORD1(24'h040000),
        .HOLDOFF(HOLDOFF),
        .DAC_BASE_ADDR(8'h08)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .upd_valid_i(upd_valid_i),
        .upd_ready_o(upd_ready_o),
        .upd_data_i(upd_data_i),
        .upd_mask_i(upd_mask_i),
        .iface_data_o(iface_data_o),
        .iface_valid_o(iface_valid_o),
        .iface_busy_i(iface_busy_i),
        .init_done_o(init_done_o),
        .busy_o(busy_o),
        .done_o(done_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [31:0] exp_q[$];
    int          per_q[$];
    logic [15:0] shadow[4];
    int          busy_lo = 20;
    int          busy_hi = 20;
    int          busy_cnt = 0;
    int          cyc = 0;
    int          words_seen = 0;
    int          done_cnt = 0;
    int          last_pulse = 0;
    logic [31:0] last_word = '0;
    bit          noise = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Behavioural iface: records words, checks them in order, answers with busy.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                busy_cnt  = 0;
                last_word = '0;
            end
            if (done_o) done_cnt++;
            if (iface_valid_o) begin
                check("valid_while_busy", busy_cnt, 0);
                words_seen++;
                per_q.push_back(cyc - last_pulse);
                last_pulse = cyc;
                last_word  = iface_data_o;
                if (exp_q.size() == 0)
                    check("extra_word", {32'h0, iface_data_o}, 64'h0);
                else
                    check("word", iface_data_o, exp_q.pop_front());
                busy_cnt = $urandom_range(busy_hi, busy_lo);
            end else begin
                if (busy_cnt > 0) busy_cnt--;
                if (rst_n) check("data_hold", iface_data_o, last_word);
            end
            iface_busy_i = (busy_cnt > 0) || (noise && ($urandom_range(1, 0) == 1));
        end
    end

    // Reference: ascending channels of the effective mask; the highest one carries the flag.
    task automatic model_push(input logic [63:0] d, input logic [3:0] m, output logic [3:0] eff);
        int hi;
        logic [31:0] w;
        eff = m;
`ifdef GPA_FHDO_SEQ_SKIP_UNCHANGED_EN
        for (int i = 0; i < 4; i++)
            if (d[16*i +: 16] == shadow[i]) eff[i] = 1'b0;
`endif
        hi = -1;
        for (int i = 0; i < 4; i++)
            if (eff[i]) hi = i;
        for (int i = 0; i < 4; i++) begin
            if (eff[i]) begin
                w = 32'(i) * 32'h0200_0000 + ((i == hi) ? 32'h0100_0000 : 32'h0)
                    + (32'h8 + 32'(i)) * 32'h0001_0000 + {16'h0, d[16*i +: 16]};
                exp_q.push_back(w);
                shadow[i] = d[16*i +: 16];
            end
        end
    endtask

    task automatic wait_cycles_until_done(input int limit);
        int n;
        n = 0;
        while (!done_o && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("done_timeout", done_o, 1);
    endtask

    task automatic accept_update(input logic [63:0] d, input logic [3:0] m, output logic [3:0] eff);
        int n;
        n = 0;
        while (!upd_ready_o && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("ready_timeout", upd_ready_o, 1);
        model_push(d, m, eff);
        upd_data_i  = d;
        upd_mask_i  = m;
        upd_valid_i = 1'b1;
        @(posedge clk);
        #1;
        upd_valid_i = 1'b0;
        upd_data_i  = {$urandom, $urandom};
        upd_mask_i  = 4'($urandom_range(15, 0));
    endtask

    task automatic send_update(input logic [63:0] d, input logic [3:0] m);
        logic [3:0] eff;
        int dc0;
        dc0 = done_cnt;
        accept_update(d, m, eff);
        if (eff == 4'd0) begin
            check("done_zero_mask", done_o, 1);
            check("ready_zero_mask", upd_ready_o, 1);
            check("busy_zero_mask", busy_o, 0);
        end else begin
            check("ready_drop", upd_ready_o, 0);
            check("busy_rise", busy_o, 1);
            wait_cycles_until_done(2000);
        end
        @(posedge clk);
        #1;
        check("done_width", done_o, 0);
        check("done_count", done_cnt - dc0, 1);
        check("words_left", exp_q.size(), 0);
        check("ready_after", upd_ready_o, 1);
        check("busy_after", busy_o, 0);
    endtask

    task automatic do_init(input bit hold_valid);
        int base;
        int n;
        base = words_seen;
        for (int i = 0; i < 4; i++) shadow[i] = 16'h0;
        exp_q.delete();
        exp_q.push_back(INIT0);
        exp_q.push_back(INIT1);
        busy_lo = 20;
        busy_hi = 20;
        @(negedge clk);
        rst_n = 1'b1;
        if (hold_valid) begin
            upd_valid_i = 1'b1;
            upd_mask_i  = 4'hF;
            upd_data_i  = {$urandom, $urandom};
            repeat (10) begin
                @(posedge clk);
                #1;
            end
            check("ready_during_init", upd_ready_o, 0);
            check("busy_during_init", busy_o, 1);
            upd_valid_i = 1'b0;
        end
        n = 0;
        while (!init_done_o && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("init_done", init_done_o, 1);
        check("init_words", words_seen - base, 2);
        check("init_left", exp_q.size(), 0);
        check("init_after_busy", (cyc - last_pulse) >= 20, 1);
        check("ready_after_init", upd_ready_o, 1);
        check("busy_after_init", busy_o, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, iface_data_o, 0);
        check({tag, "_valid"}, iface_valid_o, 0);
        check({tag, "_ready"}, upd_ready_o, 0);
        check({tag, "_init_done"}, init_done_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        logic [3:0]  eff;
        int          base;
        int          n;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        do_init(1'b1);

        busy_lo = 0;
        busy_hi = 3;
        send_update(64'h0004_0003_0002_0001, 4'hF);
        send_update(64'h5555_ABCD_7777_1234, 4'b0101);
        send_update({$urandom, $urandom}, 4'h0);

        // Busy activity while idle must not matter.
        noise = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
        end
        check("noise_ready", upd_ready_o, 1);
        check("noise_busy", busy_o, 0);
        noise = 1'b0;
        @(posedge clk);
        #1;

        // Minimum word period with busy held low.
        busy_lo = 0;
        busy_hi = 0;
        per_q.delete();
        send_update(64'h1111_2222_3333_4444, 4'hF);
        check("period_count", per_q.size(), 4);
        for (int i = 1; i < 4; i++)
            if (i < per_q.size()) check("period", per_q[i], 2 + HOLDOFF);

        send_update(64'h0004_0003_0002_0001, 4'hF);
        send_update(64'h0004_0009_0002_0001, 4'hF);

        d = {$urandom, $urandom};
        for (int k = 0; k < 40; k++) begin
            busy_lo = 0;
            busy_hi = $urandom_range(4, 0);
            if ($urandom_range(2, 0) == 0) begin
                d = {$urandom, $urandom};
            end else if ($urandom_range(1, 0) == 1) begin
                n = $urandom_range(3, 0);
                d[16*n +: 16] = 16'($urandom);
            end
            send_update(d, 4'($urandom_range(15, 0)));
        end

        // Reset while the third word of an update is waiting on busy.
        busy_lo = 10;
        busy_hi = 10;
        base = words_seen;
        accept_update(64'hAAAA_BBBB_CCCC_DDDD, 4'hF, eff);
        n = 0;
        while ((words_seen - base) < 3 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("third_word_seen", words_seen - base, 3);
        repeat (HOLDOFF + 1) begin
            @(posedge clk);
            #1;
        end
        check("in_wait_busy", busy_o, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("held_reset");
        do_init(1'b0);
        base = words_seen;
        repeat (30) begin
            @(posedge clk);
            #1;
        end
        check("no_resume", words_seen - base, 0);

        busy_lo = 0;
        busy_hi = 2;
        send_update(64'h0004_0003_0002_0001, 4'b1010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
